// File: rtl/serial_borrow_subtractor.sv
// ---------------------------------------------------------------------------
// serial_borrow_subtractor
//   Bit-serial WIDTH-bit subtractor computing a - b - b_in, one bit per clock,
//   LSB first, through a single full-subtractor cell. A start/busy/done
//   handshake allows back-to-back issue: a start seen in the DONE cycle
//   launches the next operation immediately.
//
// Ports
//   clk_i     rising-edge clock
//   reset_i   synchronous active-high reset; aborts any operation in flight
//   start_i   request, honoured only in IDLE or DONE
//   a_i       minuend, captured on an accepted start
//   b_i       subtrahend, captured on an accepted start
//   b_in_i    borrow-in, captured on an accepted start
//   busy_o    high for the WIDTH cycles an operation is running
//   done_o    one-cycle pulse; diff_o/b_out_o valid from this cycle on
//   diff_o    a - b - b_in modulo 2^WIDTH
//   b_out_o   borrow-out, 1 iff a < b + b_in (unsigned)
// ---------------------------------------------------------------------------
module serial_borrow_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             b_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             b_out_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    // Full-subtractor cell working on the current LSB of the operand shifters.
    logic d_bit_d;
    logic br_d;

    always_comb begin
        d_bit_d = a_q[0] ^ b_q[0] ^ br_q;
        br_d    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        a_q     <= a_i;
                        b_q     <= b_i;
                        br_q    <= b_in_i;
                        res_q   <= '0;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    // Result bits enter at the MSB so that after WIDTH shifts
                    // the first (LSB) bit has reached position 0.
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    br_q  <= br_d;
                    res_q <= {d_bit_d, res_q[WIDTH-1:1]};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        diff_q  <= {d_bit_d, res_q[WIDTH-1:1]};
                        bout_q  <= br_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign diff_o  = diff_q;
    assign b_out_o = bout_q;

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_borrow_subtractor
//   Directed bench for serial_borrow_subtractor. A timeline model (operation
//   accepted at edge e completes at edge e+WIDTH, arithmetic done with plain
//   wide subtraction) is checked against the DUT on every negedge, and
//   hand-computed literal results pin the model.
// ---------------------------------------------------------------------------
module tb_serial_borrow_subtractor;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             b_out;

    int checks = 0;
    int errors = 0;

    serial_borrow_subtractor #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .b_in_i  (b_in),
        .busy_o  (busy),
        .done_o  (done),
        .diff_o  (diff),
        .b_out_o (b_out)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    int               edge_n   = 0;
    bit               seen     = 1'b0;
    bit               pend     = 1'b0;
    int               due      = 0;
    logic [WIDTH:0]   pend_res = '0;
    logic [WIDTH-1:0] m_diff   = '0;
    logic             m_bout   = 1'b0;
    logic             m_busy   = 1'b0;
    logic             m_done   = 1'b0;

    always @(posedge clk) begin
        bit can_accept;
        edge_n = edge_n + 1;
        seen   = 1'b1;
        if (reset) begin
            pend   = 1'b0;
            m_diff = '0;
            m_bout = 1'b0;
            m_done = 1'b0;
            m_busy = 1'b0;
        end else begin
            can_accept = !pend;
            m_done = 1'b0;
            if (pend && edge_n == due) begin
                m_diff = pend_res[WIDTH-1:0];
                m_bout = pend_res[WIDTH];
                m_done = 1'b1;
                pend   = 1'b0;
            end
            if (start && can_accept) begin
                pend     = 1'b1;
                due      = edge_n + WIDTH;
                pend_res = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, b_in};
            end
            m_busy = pend;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (seen) begin
            checks = checks + 1;
            if (busy !== m_busy || done !== m_done || diff !== m_diff || b_out !== m_bout) begin
                errors = errors + 1;
                $display("FAIL cycle%0d: busy=%b done=%b diff=%b b_out=%b, required busy=%b done=%b diff=%b b_out=%b",
                         edge_n, busy, done, diff, b_out, m_busy, m_done, m_diff, m_bout);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi);
        @(negedge clk);
        a = av; b = bv; b_in = bi; start = 1'b1;
    endtask

    // Called right after issue(): drops start, then waits for done.
    // lat counts negedges from the issuing negedge, nbusy the busy cycles seen.
    task automatic wait_done(output int lat, output int nbusy);
        lat = 0; nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            lat = lat + 1;
            if (done) break;
            if (busy) nbusy = nbusy + 1;
        end
        if (!done) begin
            errors = errors + 1;
            $display("FAIL timeout: done not seen within 20 cycles");
        end
    endtask

    int lat, nb;

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;

        // 1. reset
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_diff", int'(diff), 0);
        chk("reset_bout", int'(b_out), 0);
        reset = 1'b0;

        // 2. 0101 - 1011 - 1
        issue(4'b0101, 4'b1011, 1'b1);
        wait_done(lat, nb);
        chk("t2_latency", lat, 5);
        chk("t2_diff", int'(diff), 9);
        chk("t2_bout", int'(b_out), 1);

        // 3. 0111 - 1001 - 0, busy exactly 4 cycles
        issue(4'b0111, 4'b1001, 1'b0);
        wait_done(lat, nb);
        chk("t3_diff", int'(diff), 14);
        chk("t3_bout", int'(b_out), 1);
        chk("t3_busy_cycles", nb, 4);

        // 4. back-to-back, second start held in the DONE cycle
        issue(4'b0110, 4'b1100, 1'b1);
        wait_done(lat, nb);
        chk("t4a_diff", int'(diff), 9);
        chk("t4a_bout", int'(b_out), 1);
        a = 4'b1100; b = 4'b0110; b_in = 1'b0; start = 1'b1;
        wait_done(lat, nb);
        chk("t4b_gap", lat, 5);
        chk("t4b_diff", int'(diff), 6);
        chk("t4b_bout", int'(b_out), 0);

        // 5. start mid-RUN is ignored
        issue(4'b1010, 4'b0011, 1'b0);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        a = 4'b0001; b = 4'b1111; b_in = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(lat, nb);
        chk("t5_diff", int'(diff), 7);
        chk("t5_bout", int'(b_out), 0);
        repeat (6) @(negedge clk);
        chk("t5_no_extra_done", int'(done), 0);

        // 6. reset on the 2nd RUN cycle
        issue(4'b1001, 4'b0010, 1'b0);
        @(negedge clk); start = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) nb = nb + 1;
        end
        chk("t6_no_done", nb, 0);
        chk("t6_diff", int'(diff), 0);
        chk("t6_bout", int'(b_out), 0);
        issue(4'b0000, 4'b0000, 1'b1);
        wait_done(lat, nb);
        chk("t6_diff_ones", int'(diff), 15);
        chk("t6_bout_one", int'(b_out), 1);

        // a = b, b_in = 0
        issue(4'b1101, 4'b1101, 1'b0);
        wait_done(lat, nb);
        chk("eq_diff", int'(diff), 0);
        chk("eq_bout", int'(b_out), 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
